// File: rtl/truth_table_scanner_if.sv
// Bundle between the truth-table scanner and the combinational function it probes.
// The master side drives start and f_in; the slave side is the scanner.
interface truth_table_scanner_if #(
    parameter int N = 2
);
    logic                start;
    logic                f_in;
    logic [N-1:0]        x_out;
    logic [N-1:0]        m_out;
    logic                busy;
    logic                done;
    logic [(2**N)-1:0]   mask;
    logic [N:0]          count;
    logic                all_one;
    logic                all_zero;

    modport master (
        output start, f_in,
        input  x_out, m_out, busy, done, mask, count, all_one, all_zero
    );

    modport slave (
        input  start, f_in,
        output x_out, m_out, busy, done, mask, count, all_one, all_zero
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Sweeps all 2^N input combinations of a combinational function and collects its minterm mask.
// Latency: done pulses 2^N*(SETTLE+1) edges after the accepted start.
// Backpressure: none; start is ignored while busy, accepted in IDLE or in the DONE cycle.
module truth_table_scanner #(
    parameter int N      = 2,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_scanner_if.slave bus
);
    localparam logic [N-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [N-1:0]        idx;
    logic [3:0]          settle;
    logic [(2**N)-1:0]   mask;
    logic [(2**N)-1:0]   mask_nxt;
    logic [N:0]          count;
    logic                all_one, all_zero;
    logic                load, sample, last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sample    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = SCAN;
                load      = 1'b1;
            end
            SCAN: if (settle == 4'd0) begin
                sample = 1'b1;
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // A start in the done cycle chains straight into the next scan.
                if (bus.start) begin
                    state_nxt = SCAN;
                    load      = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Mask including the bit sampled this cycle, so flags see the final minterm.
    always_comb begin
        mask_nxt      = mask;
        mask_nxt[idx] = bus.f_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            settle   <= 4'd0;
            mask     <= '0;
            count    <= '0;
            all_one  <= 1'b0;
            all_zero <= 1'b0;
        end else if (load) begin
            idx      <= '0;
            settle   <= 4'(SETTLE);
            mask     <= '0;
            count    <= '0;
            all_one  <= 1'b0;
            all_zero <= 1'b0;
        end else if (state == SCAN) begin
            if (!sample) begin
                settle <= settle - 4'd1;
            end else begin
                mask  <= mask_nxt;
                count <= count + (N+1)'(bus.f_in);
                if (last) begin
                    all_one  <= &mask_nxt;
                    all_zero <= ~|mask_nxt;
                end else begin
                    idx    <= idx + N'(1);
                    settle <= 4'(SETTLE);
                end
            end
        end
    end

    assign bus.x_out    = idx;
    assign bus.m_out    = idx;
    assign bus.busy     = (state == SCAN);
    assign bus.done     = (state == DONE);
    assign bus.mask     = mask;
    assign bus.count    = count;
    assign bus.all_one  = all_one;
    assign bus.all_zero = all_zero;
endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: two scanners (SETTLE=0 and SETTLE=2) probing a selectable 2-input function.
module tb_truth_table_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    truth_table_scanner_if #(.N(2)) if0 ();
    truth_table_scanner_if #(.N(2)) if2 ();

    truth_table_scanner #(.N(2), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    truth_table_scanner #(.N(2), .SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // Function codes: 0 taut ~((a^b)&(a&b)), 1 a&b, 2 a^b, 3 const 0, 4 a, 5 ~b
    logic [2:0] fsel = 3'd0;
    logic       use2 = 1'b0;

    function automatic logic f_model(input logic [2:0] code, input logic [1:0] x);
        logic a, b;
        a = x[1];
        b = x[0];
        case (code)
            3'd0:    return ~((a ^ b) & (a & b));
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return 1'b0;
            3'd4:    return a;
            3'd5:    return ~b;
            default: return 1'b0;
        endcase
    endfunction

    assign if0.f_in = f_model(fsel, if0.x_out);
    assign if2.f_in = f_model(fsel, if2.x_out);

    logic       cur_done, cur_busy, cur_one, cur_zero;
    logic [3:0] cur_mask;
    logic [2:0] cur_count;
    logic [1:0] cur_x;
    assign cur_done  = use2 ? if2.done     : if0.done;
    assign cur_busy  = use2 ? if2.busy     : if0.busy;
    assign cur_one   = use2 ? if2.all_one  : if0.all_one;
    assign cur_zero  = use2 ? if2.all_zero : if0.all_zero;
    assign cur_mask  = use2 ? if2.mask     : if0.mask;
    assign cur_count = use2 ? if2.count    : if0.count;
    assign cur_x     = use2 ? if2.x_out    : if0.x_out;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (use2) if2.start = v;
        else      if0.start = v;
    endtask

    // Starts a scan at the next edge E0 and returns the number of edges after E0 until done.
    task automatic do_scan(input logic [2:0] code, output int lat);
        fsel = code;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        lat = 0;
        while (!cur_done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0] code;
        logic [3:0] exp_mask;
        logic [2:0] exp_count;
        logic       exp_one;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat;
        int ndone;
        int xbad;
        logic [1:0] xexp;

        vecs[0] = '{3'd0, 4'b1111, 3'd4, 1'b1, 1'b0};
        vecs[1] = '{3'd1, 4'b1000, 3'd1, 1'b0, 1'b0};
        vecs[2] = '{3'd2, 4'b0110, 3'd2, 1'b0, 1'b0};
        vecs[3] = '{3'd3, 4'b0000, 3'd0, 1'b0, 1'b1};
        vecs[4] = '{3'd4, 4'b1100, 3'd2, 1'b0, 1'b0};
        vecs[5] = '{3'd5, 4'b0101, 3'd2, 1'b0, 1'b0};

        if0.start = 1'b0;
        if2.start = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(if0.busy),  32'd0);
        chk("rst_done",  32'(if0.done),  32'd0);
        chk("rst_x",     32'(if0.x_out), 32'd0);
        chk("rst_mask",  32'(if0.mask),  32'd0);
        chk("rst_count", 32'(if0.count), 32'd0);
        chk("rst_flags", {30'd0, if0.all_one, if0.all_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of functions on the SETTLE=0 scanner
        for (int i = 0; i < 6; i++) begin
            do_scan(vecs[i].code, lat);
            chk("lat",   32'(lat),       32'd4);
            chk("mask",  32'(cur_mask),  32'(vecs[i].exp_mask));
            chk("count", 32'(cur_count), 32'(vecs[i].exp_count));
            chk("one",   32'(cur_one),   32'(vecs[i].exp_one));
            chk("zero",  32'(cur_zero),  32'(vecs[i].exp_zero));
            chk("busy_at_done", 32'(cur_busy), 32'd0);
            @(posedge clk);
            #1;
            chk("done_width", 32'(cur_done), 32'd0);
            chk("hold_mask",  32'(cur_mask), 32'(vecs[i].exp_mask));
            chk("hold_x",     32'(cur_x),    32'd3);
        end

        // SETTLE=2: each index held 3 cycles, done on edge 12
        use2 = 1'b1;
        fsel = 3'd2;
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk);
        #1;
        set_start(1'b0);
        xbad = 0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            xexp = 2'(k / 3);
            if (cur_x !== xexp || cur_busy !== 1'b1) xbad++;
            if (cur_done) ndone++;
            @(posedge clk);
            #1;
        end
        chk("s2_x_sequence", 32'(xbad), 32'd0);
        chk("s2_no_early_done", 32'(ndone), 32'd0);
        chk("s2_done_edge12", 32'(cur_done), 32'd1);
        chk("s2_mask", 32'(cur_mask), 32'h6);
        @(posedge clk);
        #1;
        chk("s2_done_width", 32'(cur_done), 32'd0);
        use2 = 1'b0;

        // Start while busy is ignored
        fsel = 3'd2;
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_x1", 32'(if0.x_out), 32'd1);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        ndone = 0;
        lat = 2;
        for (int k = 0; k < 10; k++) begin
            if (if0.done) begin
                ndone++;
                if (ndone == 1) chk("mid_lat", 32'(lat), 32'd4);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mid_done_count", 32'(ndone), 32'd1);
        chk("mid_mask", 32'(if0.mask), 32'h6);

        // Reset mid-scan at x_out=2
        fsel = 3'd0;
        @(negedge clk);
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_x2", 32'(if0.x_out), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(if0.busy),  32'd0);
        chk("arst_x",    32'(if0.x_out), 32'd0);
        chk("arst_mask", 32'(if0.mask),  32'd0);
        chk("arst_count",32'(if0.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_scan(3'd1, lat);
        chk("post_rst_lat",  32'(lat),        32'd4);
        chk("post_rst_mask", 32'(if0.mask),   32'h8);
        chk("post_rst_cnt",  32'(if0.count),  32'd1);

        // Start in the DONE cycle: back-to-back scan
        fsel = 3'd5;
        if0.start = 1'b1;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
        chk("b2b_busy",  32'(if0.busy),  32'd1);
        chk("b2b_clear", {27'd0, if0.count, if0.mask[1:0]}, 32'd0);
        lat = 0;
        while (!if0.done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_lat",   32'(lat),       32'd4);
        chk("b2b_mask",  32'(if0.mask),  32'h5);
        chk("b2b_count", 32'(if0.count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
